// File: rtl/tq_qp_divmod.sv
// Sequential QP divider: restoring division by a constant divisor, one
// quotient bit per cycle, MSB first, with optional clamp to QP_MAX and a
// pass-through channel tag. Sits between QP control and the scaling-table
// lookups.
module tq_qp_divmod #(
  parameter int unsigned QP_W   = 6,
  parameter int unsigned DIV    = 6,
  parameter int unsigned QP_MAX = 51,
  parameter int unsigned TAG_W  = 2,
  localparam int unsigned R_W   = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [QP_W-1:0]  qp_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             sat_en_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [QP_W-1:0]  qp_per_o,
  output logic [R_W-1:0]   qp_rem_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             sat_o
);

  localparam int unsigned CNT_W = (QP_W > 1) ? $clog2(QP_W) : 1;
  localparam logic [R_W:0]      DIV_T    = (R_W+1)'(DIV);
  localparam logic [QP_W-1:0]   QP_MAX_T = QP_W'(QP_MAX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(QP_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [QP_W-1:0]    dvd_q, dvd_d;
  logic [QP_W-1:0]    quot_q, quot_d;
  logic [R_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               sat_q, sat_d;
  logic [R_W:0]       trial;
  logic               q_bit;

  // Next-state logic: accept and clamp in IDLE, one restoring step per BUSY
  // cycle (dividend shifts out MSB first), hold the result in DONE.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    sat_d   = sat_q;
    trial   = {rem_q, dvd_q[QP_W-1]};
    q_bit   = (trial >= DIV_T);
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (sat_en_i && (32'(qp_i) > QP_MAX)) begin
            dvd_d = QP_MAX_T;
            sat_d = 1'b1;
          end else begin
            dvd_d = qp_i;
            sat_d = 1'b0;
          end
          tag_d   = tag_i;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CNT_LAST;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (q_bit) begin
          rem_d = R_W'(trial - DIV_T);
        end else begin
          rem_d = R_W'(trial);
        end
        quot_d = (quot_q << 1) | QP_W'(q_bit);
        dvd_d  = dvd_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight request and clears outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign qp_per_o    = quot_q;
  assign qp_rem_o    = rem_q;
  assign tag_o       = tag_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_tq_qp_divmod.sv
// Self-checking bench for tq_qp_divmod: default instance (6-bit QP, /6) and
// an 8-bit /10 variant with QP_MAX = 200, checked against plain-arithmetic
// division in the bench.
module tb_tq_qp_divmod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, sat_en, sat_o;
  logic [5:0] qp, per;
  logic [2:0] rem;
  logic [1:0] tag, tag_o;

  logic       v_in_valid, v_in_ready, v_out_valid, v_out_ready, v_sat_en, v_sat_o;
  logic [7:0] v_qp, v_per;
  logic [3:0] v_rem;
  logic [1:0] v_tag, v_tag_o;

  int tests = 0;
  int fails = 0;

  tq_qp_divmod dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .qp_i(qp), .tag_i(tag), .sat_en_i(sat_en),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .qp_per_o(per), .qp_rem_o(rem), .tag_o(tag_o), .sat_o(sat_o)
  );

  tq_qp_divmod #(.QP_W(8), .DIV(10), .QP_MAX(200), .TAG_W(2)) dut_v (
    .clk(clk), .rst(rst),
    .in_valid_i(v_in_valid), .in_ready_o(v_in_ready),
    .qp_i(v_qp), .tag_i(v_tag), .sat_en_i(v_sat_en),
    .out_valid_o(v_out_valid), .out_ready_i(v_out_ready),
    .qp_per_o(v_per), .qp_rem_o(v_rem), .tag_o(v_tag_o), .sat_o(v_sat_o)
  );

  typedef struct {
    int qp;
    int tag;
    bit sat_en;
    int per;
    int rem;
    bit sat;
  } vec_t;

  // Record one comparison, reporting any difference.
  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: clamp if requested, then integer divide and modulo.
  task automatic refModel(input int q, input bit s, input int divisor, input int qmax,
                          output int e_per, output int e_rem, output bit e_sat);
    int d;
    e_sat = s && (q > qmax);
    d     = e_sat ? qmax : q;
    e_per = d / divisor;
    e_rem = d % divisor;
  endtask

  // Issue one request on the default instance and wait for its result.
  task automatic applyStimulus(input int q, input int t, input bit s, output int lat);
    qp = 6'(q); tag = 2'(t); sat_en = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  // Issue one request on the wide variant and wait for its result.
  task automatic applyVariant(input int q, input int t, input bit s, output int lat);
    v_qp = 8'(q); v_tag = 2'(t); v_sat_en = s; v_in_valid = 1'b1;
    @(posedge clk); #1;
    v_in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!v_out_valid && lat < 40);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[7];
    int   lat, e_per, e_rem, seen;
    bit   e_sat;

    vecs[0] = '{qp: 0,  tag: 0, sat_en: 1'b0, per: 0, rem: 0, sat: 1'b0};
    vecs[1] = '{qp: 29, tag: 1, sat_en: 1'b0, per: 4, rem: 5, sat: 1'b0};
    vecs[2] = '{qp: 30, tag: 3, sat_en: 1'b0, per: 5, rem: 0, sat: 1'b0};
    vecs[3] = '{qp: 39, tag: 0, sat_en: 1'b0, per: 6, rem: 3, sat: 1'b0};
    vecs[4] = '{qp: 51, tag: 1, sat_en: 1'b0, per: 8, rem: 3, sat: 1'b0};
    vecs[5] = '{qp: 63, tag: 2, sat_en: 1'b1, per: 8, rem: 3, sat: 1'b1};
    vecs[6] = '{qp: 51, tag: 2, sat_en: 1'b1, per: 8, rem: 3, sat: 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; qp = '0; tag = '0; sat_en = 1'b0; out_ready = 1'b1;
    v_in_valid = 1'b0; v_qp = '0; v_tag = '0; v_sat_en = 1'b0; v_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset per", int'(per), 0);
    checkOutput("reset rem", int'(rem), 0);
    checkOutput("reset tag", int'(tag_o), 0);
    checkOutput("reset sat", int'(sat_o), 0);
    checkOutput("reset v in_ready", int'(v_in_ready), 1);
    checkOutput("reset v out_valid", int'(v_out_valid), 0);

    // Spot-check table including saturation cases.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].qp, vecs[i].tag, vecs[i].sat_en, lat);
      checkOutput($sformatf("vec%0d per", i), int'(per), vecs[i].per);
      checkOutput($sformatf("vec%0d rem", i), int'(rem), vecs[i].rem);
      checkOutput($sformatf("vec%0d tag", i), int'(tag_o), vecs[i].tag);
      checkOutput($sformatf("vec%0d sat", i), int'(sat_o), int'(vecs[i].sat));
      checkOutput($sformatf("vec%0d latency", i), lat, 6);
      @(posedge clk); #1;
    end

    // Exhaustive unclamped sweep.
    for (int q = 0; q < 64; q++) begin
      refModel(q, 1'b0, 6, 51, e_per, e_rem, e_sat);
      applyStimulus(q, q % 4, 1'b0, lat);
      checkOutput($sformatf("sweep%0d per", q), int'(per), e_per);
      checkOutput($sformatf("sweep%0d rem", q), int'(rem), e_rem);
      checkOutput($sformatf("sweep%0d latency", q), lat, 6);
      @(posedge clk); #1;
    end

    // Random requests with random clamp enable and tag.
    for (int n = 0; n < 24; n++) begin
      int  rq, rt;
      bit  rs;
      rq = int'($urandom_range(63));
      rt = int'($urandom_range(3));
      rs = 1'($urandom_range(1));
      refModel(rq, rs, 6, 51, e_per, e_rem, e_sat);
      applyStimulus(rq, rt, rs, lat);
      checkOutput($sformatf("rand%0d per", n), int'(per), e_per);
      checkOutput($sformatf("rand%0d rem", n), int'(rem), e_rem);
      checkOutput($sformatf("rand%0d tag", n), int'(tag_o), rt);
      checkOutput($sformatf("rand%0d sat", n), int'(sat_o), int'(e_sat));
      @(posedge clk); #1;
    end

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    applyStimulus(17, 1, 1'b0, lat);
    checkOutput("bp latency", lat, 6);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid", int'(out_valid), 1);
      checkOutput("bp per", int'(per), 2);
      checkOutput("bp rem", int'(rem), 5);
      checkOutput("bp in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp release out_valid", int'(out_valid), 0);
    checkOutput("bp release in_ready", int'(in_ready), 1);

    // New request presented during BUSY must wait until IDLE.
    qp = 6'd10; tag = 2'd1; sat_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    checkOutput("busy in_ready drop", int'(in_ready), 0);
    qp = 6'd40; tag = 2'd3;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("busy first per", int'(per), 1);
    checkOutput("busy first rem", int'(rem), 4);
    checkOutput("busy first tag", int'(tag_o), 1);
    checkOutput("busy first latency", lat, 6);
    @(posedge clk); #1;
    checkOutput("busy idle in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("busy second per", int'(per), 6);
    checkOutput("busy second rem", int'(rem), 4);
    checkOutput("busy second tag", int'(tag_o), 3);
    checkOutput("busy second latency", lat, 6);
    @(posedge clk); #1;

    // Reset during the third BUSY cycle discards the request.
    qp = 6'd63; tag = 2'd3; sat_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst in_ready", int'(in_ready), 1);
    checkOutput("midrst out_valid", int'(out_valid), 0);
    checkOutput("midrst per", int'(per), 0);
    checkOutput("midrst rem", int'(rem), 0);
    checkOutput("midrst tag", int'(tag_o), 0);
    checkOutput("midrst sat", int'(sat_o), 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("midrst stale valid cycles", seen, 0);

    // Wide variant: clamp to 200, divide by 10, 8-cycle latency.
    applyVariant(255, 2, 1'b1, lat);
    checkOutput("var255 per", int'(v_per), 20);
    checkOutput("var255 rem", int'(v_rem), 0);
    checkOutput("var255 sat", int'(v_sat_o), 1);
    checkOutput("var255 tag", int'(v_tag_o), 2);
    checkOutput("var255 latency", lat, 8);
    @(posedge clk); #1;
    for (int n = 0; n < 8; n++) begin
      int  rq;
      bit  rs;
      rq = int'($urandom_range(255));
      rs = 1'($urandom_range(1));
      refModel(rq, rs, 10, 200, e_per, e_rem, e_sat);
      applyVariant(rq, n % 4, rs, lat);
      checkOutput($sformatf("var rand%0d per", n), int'(v_per), e_per);
      checkOutput($sformatf("var rand%0d rem", n), int'(v_rem), e_rem);
      checkOutput($sformatf("var rand%0d sat", n), int'(v_sat_o), int'(e_sat));
      checkOutput($sformatf("var rand%0d latency", n), lat, 8);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
